// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and loader state encoding
package cpu_pkg;

  localparam int IMEM_AW = 8;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } loader_state_t;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x DW instruction RAM, synchronous write, registered read
module imem_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Array contents are deliberately left unreset; only the read register clears.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads program words into imem, then serves fetches; option IMEM_LOADER_CHECKSUM_EN
module imem_loader
  import cpu_pkg::*;
#(
  parameter int AW = IMEM_AW,
  parameter int DW = INSTR_W,
  parameter logic [DW-1:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic          fetch_en,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_data,
  output logic          fetch_valid,
  output logic          loading,
  output logic          done,
  output logic [AW:0]   word_count,
  output logic          overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  localparam int DEPTH = 1 << AW;

  loader_state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   word_count_q;
  logic          overflow_q;
  logic          fetch_valid_q;
  logic          sel_nop_q;
  logic          clear;
  logic          wr_en;
  logic          rd_en;
  logic          last_loc;
  logic [DW-1:0] rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start always wins over a simultaneous transfer: the word is accepted but dropped.
  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    wr_en    = 1'b0;
    last_loc = (wr_ptr_q == AW'(DEPTH - 1));
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          clear   = 1'b1;
        end
      end
      LOAD: begin
        if (start) begin
          clear = 1'b1;
        end else if (in_valid) begin
          wr_en = 1'b1;
          if (in_last || last_loc) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (start) begin
          state_d = LOAD;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else if (clear) begin
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else if (wr_en) begin
      wr_ptr_q     <= wr_ptr_q + AW'(1);
      word_count_q <= word_count_q + (AW + 1)'(1);
      if (!in_last && last_loc) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign rd_en = fetch_en && (state_q == RUN);

  // The NOP select is captured alongside the RAM read so fetch_data holds between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      sel_nop_q     <= 1'b0;
    end else begin
      fetch_valid_q <= rd_en;
      if (rd_en) begin
        sel_nop_q <= ({1'b0, fetch_addr} >= word_count_q);
      end
    end
  end

  imem_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (fetch_addr),
    .rd_data (rd_data)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (clear) begin
      checksum_q <= '0;
    end else if (wr_en) begin
      checksum_q <= checksum_q + in_data;
    end
  end

  assign checksum = checksum_q;
`endif

  assign in_ready    = (state_q == LOAD);
  assign loading     = (state_q == LOAD);
  assign done        = (state_q == RUN);
  assign word_count  = word_count_q;
  assign overflow    = overflow_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = sel_nop_q ? NOP_WORD : rd_data;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed vector bench for imem_loader
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        fetch_en;
  logic [7:0]  fetch_addr;
  logic [15:0] fetch_data;
  logic        fetch_valid;
  logic        loading;
  logic        done;
  logic [8:0]  word_count;
  logic        overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_vec;
  int n_bad;

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .loading     (loading),
    .done        (done),
    .word_count  (word_count),
    .overflow    (overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        fe;
    logic [7:0]  fa;
    logic        e_rdy;
    logic        e_done;
    logic [8:0]  e_wc;
    logic        e_ov;
    logic        e_fv;
    logic [15:0] e_fd;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(logic st, logic v, logic [15:0] d, logic l, logic fe,
                              logic [7:0] fa, logic e_rdy, logic e_done, logic [8:0] e_wc,
                              logic e_ov, logic e_fv, logic [15:0] e_fd);
    vec_t r;
    r.st = st; r.v = v; r.d = d; r.l = l; r.fe = fe; r.fa = fa;
    r.e_rdy = e_rdy; r.e_done = e_done; r.e_wc = e_wc;
    r.e_ov = e_ov; r.e_fv = e_fv; r.e_fd = e_fd;
    return r;
  endfunction

  function automatic logic [15:0] ovf_word(int i);
    return 16'(i * 3 + 16'h1000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0;
    fetch_en = 1'b0; fetch_addr = 8'h0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " in_ready"},    32'(in_ready),    32'h0);
    chk({tag, " loading"},     32'(loading),     32'h0);
    chk({tag, " done"},        32'(done),        32'h0);
    chk({tag, " overflow"},    32'(overflow),    32'h0);
    chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'h0);
    chk({tag, " fetch_data"},  32'(fetch_data),  32'h0);
    chk({tag, " word_count"},  32'(word_count),  32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    idle_inputs();
    rst_n = 1'b0;

    //            st v  data      l  fe addr   rdy dn wc     ov fv fd
    vt[0]  = mk(1, 0, 16'h0000, 0, 0, 8'd0,  1, 0, 9'd0,  0, 0, 16'h0000);
    vt[1]  = mk(0, 1, 16'h1234, 0, 0, 8'd0,  1, 0, 9'd1,  0, 0, 16'h0000);
    vt[2]  = mk(0, 1, 16'hABCD, 0, 0, 8'd0,  1, 0, 9'd2,  0, 0, 16'h0000);
    vt[3]  = mk(0, 1, 16'h0F0F, 1, 0, 8'd0,  0, 1, 9'd3,  0, 0, 16'h0000);
    vt[4]  = mk(0, 0, 16'h0000, 0, 1, 8'd1,  0, 1, 9'd3,  0, 1, 16'hABCD);
    vt[5]  = mk(0, 0, 16'h0000, 0, 1, 8'd5,  0, 1, 9'd3,  0, 1, 16'h0000);
    vt[6]  = mk(0, 0, 16'h0000, 0, 0, 8'd0,  0, 1, 9'd3,  0, 0, 16'h0000);
    vt[7]  = mk(0, 0, 16'h0000, 0, 1, 8'd0,  0, 1, 9'd3,  0, 1, 16'h1234);
    vt[8]  = mk(0, 0, 16'h0000, 0, 1, 8'd2,  0, 1, 9'd3,  0, 1, 16'h0F0F);
    vt[9]  = mk(0, 0, 16'h0000, 0, 0, 8'd0,  0, 1, 9'd3,  0, 0, 16'h0F0F);
    vt[10] = mk(0, 1, 16'h5555, 0, 0, 8'd0,  0, 1, 9'd3,  0, 0, 16'h0F0F);
    vt[11] = mk(1, 0, 16'h0000, 0, 1, 8'd1,  1, 0, 9'd0,  0, 1, 16'hABCD);
    vt[12] = mk(1, 1, 16'hBEEF, 0, 0, 8'd0,  1, 0, 9'd0,  0, 0, 16'hABCD);
    vt[13] = mk(0, 1, 16'h1111, 0, 1, 8'd0,  1, 0, 9'd1,  0, 0, 16'hABCD);
    vt[14] = mk(0, 1, 16'h2222, 1, 0, 8'd0,  0, 1, 9'd2,  0, 0, 16'hABCD);
    vt[15] = mk(0, 0, 16'h0000, 0, 1, 8'd0,  0, 1, 9'd2,  0, 1, 16'h1111);
    vt[16] = mk(0, 0, 16'h0000, 0, 1, 8'd1,  0, 1, 9'd2,  0, 1, 16'h2222);
    vt[17] = mk(0, 0, 16'h0000, 0, 1, 8'd2,  0, 1, 9'd2,  0, 1, 16'h0000);

    #12;
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      start = vt[i].st; in_valid = vt[i].v; in_data = vt[i].d; in_last = vt[i].l;
      fetch_en = vt[i].fe; fetch_addr = vt[i].fa;
      step();
      chk($sformatf("v%0d in_ready", i),    32'(in_ready),    32'(vt[i].e_rdy));
      chk($sformatf("v%0d loading", i),     32'(loading),     32'(vt[i].e_rdy));
      chk($sformatf("v%0d done", i),        32'(done),        32'(vt[i].e_done));
      chk($sformatf("v%0d word_count", i),  32'(word_count),  32'(vt[i].e_wc));
      chk($sformatf("v%0d overflow", i),    32'(overflow),    32'(vt[i].e_ov));
      chk($sformatf("v%0d fetch_valid", i), 32'(fetch_valid), 32'(vt[i].e_fv));
      chk($sformatf("v%0d fetch_data", i),  32'(fetch_data),  32'(vt[i].e_fd));
    end
    idle_inputs();

    // Overflow: 256 words with no in_last fill the memory exactly.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = ovf_word(i); in_last = 1'b0;
      step();
      if (i == 254) begin
        chk("ovf wc at 255", 32'(word_count), 32'd255);
        chk("ovf loading at 255", 32'(loading), 32'h1);
        chk("ovf flag at 255", 32'(overflow), 32'h0);
      end
    end
    chk("ovf word_count", 32'(word_count), 32'd256);
    chk("ovf overflow", 32'(overflow), 32'h1);
    chk("ovf done", 32'(done), 32'h1);
    in_data = ovf_word(256);
    chk("ovf 257th in_ready", 32'(in_ready), 32'h0);
    step();
    chk("ovf 257th wc", 32'(word_count), 32'd256);
    in_valid = 1'b0;
    fetch_en = 1'b1; fetch_addr = 8'd255;
    step();
    chk("ovf fetch 255 valid", 32'(fetch_valid), 32'h1);
    chk("ovf fetch 255 data", 32'(fetch_data), 32'(ovf_word(255)));
    fetch_addr = 8'd0;
    step();
    chk("ovf fetch 0 data", 32'(fetch_data), 32'(ovf_word(0)));
    idle_inputs();

    // Reset asserted mid-load after 2 of 4 words.
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h7001;
    step();
    in_data = 16'h7002;
    step();
    chk("midrst wc before", 32'(word_count), 32'd2);
    in_data = 16'h7003;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    #1;
    rst_n = 1'b1;
    idle_inputs();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'hA1A1;
    step();
    in_data = 16'hB2B2; in_last = 1'b1;
    step();
    idle_inputs();
    chk("reload wc", 32'(word_count), 32'd2);
    chk("reload done", 32'(done), 32'h1);
    fetch_en = 1'b1; fetch_addr = 8'd0;
    step();
    chk("reload fetch 0", 32'(fetch_data), 32'hA1A1);
    fetch_addr = 8'd2;
    step();
    chk("reload fetch 2 nop", 32'(fetch_data), 32'h0000);
    chk("reload fetch 2 valid", 32'(fetch_valid), 32'h1);
    idle_inputs();

`ifdef IMEM_LOADER_CHECKSUM_EN
    start = 1'b1;
    step();
    chk("cks cleared", 32'(checksum), 32'h0);
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h0001;
    step();
    in_data = 16'hFFFF;
    step();
    in_data = 16'h0002; in_last = 1'b1;
    step();
    idle_inputs();
    chk("cks done", 32'(done), 32'h1);
    chk("cks value", 32'(checksum), 32'h0002);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
